// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and width helpers for the pipeline stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Total width of the packed {ctrl, data, reg} payload.
    function automatic int payload_width(input int ctrl_w, input int ndata,
                                         input int data_w, input int nreg,
                                         input int reg_w);
        return ctrl_w + ndata * data_w + nreg * reg_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_ctrl
// Description : Valid/ready control for pipe_stage_reg. PIPE_SKID_EN selects
//               the three-state skid FSM; otherwise a single-register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic main_from_skid
);

`ifdef PIPE_SKID_EN
    pipe_state_e r_state;
    pipe_state_e w_next;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        w_accept;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign w_accept  = in_valid & r_in_ready;

    always_comb begin
        w_next         = r_state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    load_main = 1'b1;
                    w_next    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_accept && out_ready) begin
                    load_main = 1'b1;
                end else if (w_accept) begin
                    load_skid = 1'b1;
                    w_next    = ST_FULL;
                end else if (out_ready) begin
                    w_next    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    w_next         = ST_BUSY;
                end
            end
            default: w_next = ST_EMPTY;
        endcase
        // Reset and flush discard anything accepted on this edge.
        if (rst || flush) begin
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next != ST_FULL);
            r_out_valid <= (w_next != ST_EMPTY);
        end
    end
`else
    logic r_out_valid;
    logic w_accept;

    assign out_valid      = r_out_valid;
    assign in_ready       = ~r_out_valid | out_ready;
    assign w_accept       = in_valid & in_ready;
    assign load_main      = w_accept & ~flush & ~rst;
    assign load_skid      = 1'b0;
    assign main_from_skid = 1'b0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register with valid/ready, flush and an
//               optional skid buffer enabled by defining PIPE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NDATA  = 3,
    parameter int REG_W  = REG_W_DEF,
    parameter int NREG   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NDATA*DATA_W-1:0] in_data,
    input  logic [NREG*REG_W-1:0]   in_reg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [NREG*REG_W-1:0]   out_reg
);

    localparam int PAYLOAD_W = payload_width(CTRL_W, NDATA, DATA_W, NREG, REG_W);
    localparam int DREG_W    = NDATA * DATA_W + NREG * REG_W;

    logic [PAYLOAD_W-1:0] w_in_payload;
    logic [PAYLOAD_W-1:0] r_main;
    logic [PAYLOAD_W-1:0] r_skid;
    logic                 w_load_main;
    logic                 w_load_skid;
    logic                 w_main_from_skid;

    assign w_in_payload = {in_ctrl, in_data, in_reg};

    pipe_skid_ctrl u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .load_main      (w_load_main),
        .load_skid      (w_load_skid),
        .main_from_skid (w_main_from_skid)
    );

    // In the single-register build load_skid is tied low, so r_skid stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : w_in_payload;
            end
            if (w_load_skid) begin
                r_skid <= w_in_payload;
            end
        end
    end

    assign out_ctrl = r_main[PAYLOAD_W-1 -: CTRL_W] & {CTRL_W{out_valid}};
    assign out_data = r_main[DREG_W-1 -: NDATA*DATA_W];
    assign out_reg  = r_main[NREG*REG_W-1:0];

endmodule
`default_nettype wire
